// File: rtl/avalon_pio_gen.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of output bits,
// synchronised inputs with sticky edge capture and a maskable interrupt.
module avalon_pio_gen #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_OUT = '0,
    parameter logic [WIDTH-1:0]  RESET_DIR = '0,
    parameter int unsigned       EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_mux;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Output data and direction registers, including atomic set/clear aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg  <= RESET_OUT;
            dir_reg  <= RESET_DIR;
            mask_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   out_reg  <= writedata;
                ADDR_DIR:    dir_reg  <= writedata;
                ADDR_MASK:   mask_reg <= writedata;
                ADDR_OUTSET: out_reg  <= out_reg | writedata;
                ADDR_OUTCLR: out_reg  <= out_reg & ~writedata;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = s2 & ~s3;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~s2 & s3;
        end else begin
            edge_det = s2 ^ s3;
        end
    end

    assign cap_clr = (wr_en && (address == ADDR_EDGE)) ? writedata : '0;

    // Sticky capture; a new edge beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~cap_clr) | edge_det;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = (dir_reg & out_reg) | (~dir_reg & s2);
            ADDR_DIR:  rd_mux = dir_reg;
            ADDR_MASK: rd_mux = mask_reg;
            ADDR_EDGE: rd_mux = capture;
            default:   rd_mux = '0;
        endcase
    end

    // Read data sampled from pre-write register state, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    assign out_port = out_reg;
    assign oe       = dir_reg;
    assign irq      = |(capture & mask_reg);

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Directed bench for avalon_pio_gen: a rising-edge instance with zero reset values
// and an any-edge instance with non-zero reset values share the same bus.
module tb_avalon_pio_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] address = '0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic       read_n = 1'b1;
    logic [7:0] writedata = '0;
    logic [7:0] in_port = '0;
    logic [7:0] readdata, out_port, oe;
    logic       irq;
    logic [7:0] readdata2, out_port2, oe2;
    logic       irq2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avalon_pio_gen #(.WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    avalon_pio_gen #(.WIDTH(8), .RESET_OUT(8'h5A), .RESET_DIR(8'h0F), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata2),
        .in_port(in_port), .out_port(out_port2), .oe(oe2), .irq(irq2)
    );

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic [7:0] d2);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
        d2 = readdata2;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(2);
        n_cmp++; if (out_port !== 8'h00) begin n_err++; $display("FAIL reset_out got %h exp 00", out_port); end
        n_cmp++; if (oe !== 8'h00) begin n_err++; $display("FAIL reset_oe got %h exp 00", oe); end
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL reset_rd got %h exp 00", readdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
        n_cmp++; if (out_port2 !== 8'h5A) begin n_err++; $display("FAIL reset_out2 got %h exp 5a", out_port2); end
        n_cmp++; if (oe2 !== 8'h0F) begin n_err++; $display("FAIL reset_oe2 got %h exp 0f", oe2); end
    endtask

    task automatic test_outputs;
        logic [7:0] r, r2;
        bus_write(3'd1, 8'hF0);
        bus_write(3'd0, 8'hA5);
        n_cmp++; if (out_port !== 8'hA5) begin n_err++; $display("FAIL data_wr got %h exp a5", out_port); end
        bus_write(3'd4, 8'h0A);
        n_cmp++; if (out_port !== 8'hAF) begin n_err++; $display("FAIL outset got %h exp af", out_port); end
        bus_write(3'd5, 8'h80);
        n_cmp++; if (out_port !== 8'h2F) begin n_err++; $display("FAIL outclr got %h exp 2f", out_port); end
        n_cmp++; if (oe !== 8'hF0) begin n_err++; $display("FAIL dir got %h exp f0", oe); end
        in_port = 8'h3C;
        wait_neg(3);
        bus_read(3'd0, r, r2);
        n_cmp++; if (r !== 8'h2C) begin n_err++; $display("FAIL data_rd got %h exp 2c", r); end
    endtask

    task automatic test_regmap;
        logic [7:0] r, r2;
        bus_read(3'd1, r, r2);
        n_cmp++; if (r !== 8'hF0) begin n_err++; $display("FAIL dir_rd got %h exp f0", r); end
        wait_neg(3);
        n_cmp++; if (readdata !== 8'hF0) begin n_err++; $display("FAIL rd_hold got %h exp f0", readdata); end
        bus_read(3'd4, r, r2);
        n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL outset_rd got %h exp 00", r); end
        bus_write(3'd6, 8'hFF);
        n_cmp++; if (out_port !== 8'h2F) begin n_err++; $display("FAIL addr6_wr got %h exp 2f", out_port); end
        bus_read(3'd7, r, r2);
        n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL addr7_rd got %h exp 00", r); end
        bus_write(3'd2, 8'h55);
        bus_read(3'd2, r, r2);
        n_cmp++; if (r !== 8'h55) begin n_err++; $display("FAIL mask_rd got %h exp 55", r); end
    endtask

    task automatic test_rw_same_cycle;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0; address = 3'd1; writedata = 8'h33;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        n_cmp++; if (readdata !== 8'hF0) begin n_err++; $display("FAIL rw_old got %h exp f0", readdata); end
        n_cmp++; if (oe !== 8'h33) begin n_err++; $display("FAIL rw_new got %h exp 33", oe); end
    endtask

    task automatic test_edge_irq;
        logic [7:0] r, r2;
        bus_write(3'd3, 8'hFF);
        bus_write(3'd2, 8'h01);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_pre got %b exp 0", irq); end
        @(negedge clk);
        in_port = 8'h3D;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_e1 got %b exp 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_e2 got %b exp 1", irq); end
        bus_read(3'd3, r, r2);
        n_cmp++; if (r !== 8'h01) begin n_err++; $display("FAIL edge_rd got %h exp 01", r); end
        bus_write(3'd3, 8'h01);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c got %b exp 0", irq); end
    endtask

    task automatic test_set_wins;
        logic [7:0] r, r2;
        in_port = 8'h3C;
        wait_neg(4);
        in_port = 8'h3D;
        wait_neg(4);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sw_pre got %b exp 1", irq); end
        in_port = 8'h3C;
        wait_neg(4);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sw_fall got %b exp 1", irq); end
        @(negedge clk);
        in_port = 8'h3D;
        @(negedge clk);
        bus_write(3'd3, 8'h01);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sw_irq got %b exp 1", irq); end
        bus_read(3'd3, r, r2);
        n_cmp++; if (r !== 8'h01) begin n_err++; $display("FAIL sw_edge got %h exp 01", r); end
        bus_write(3'd3, 8'h01);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL sw_clr got %b exp 0", irq); end
    endtask

    task automatic test_any_edge;
        logic [7:0] r, r2;
        bus_write(3'd2, 8'h00);
        in_port = 8'h34;
        wait_neg(4);
        bus_write(3'd3, 8'hFF);
        in_port = 8'h3C;
        wait_neg(4);
        in_port = 8'h34;
        wait_neg(4);
        bus_read(3'd3, r, r2);
        n_cmp++; if (r2 !== 8'h08) begin n_err++; $display("FAIL any_pulse got %h exp 08", r2); end
        n_cmp++; if (irq2 !== 1'b0) begin n_err++; $display("FAIL any_irq got %b exp 0", irq2); end
        in_port = 8'h3C;
        wait_neg(4);
        bus_write(3'd3, 8'hFF);
        in_port = 8'h34;
        wait_neg(4);
        bus_read(3'd3, r, r2);
        n_cmp++; if (r2 !== 8'h08) begin n_err++; $display("FAIL any_fall got %h exp 08", r2); end
        n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL rise_fall got %h exp 00", r); end
    endtask

    task automatic test_async_reset;
        logic [7:0] r, r2;
        bus_write(3'd2, 8'h01);
        bus_write(3'd1, 8'hFF);
        bus_write(3'd0, 8'hFF);
        bus_write(3'd3, 8'hFF);
        in_port = 8'h35;
        wait_neg(4);
        n_cmp++; if (irq !== 1'b1 || out_port !== 8'hFF) begin n_err++; $display("FAIL ar_pre got irq=%b out=%h exp irq=1 out=ff", irq, out_port); end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq got %b exp 0", irq); end
        n_cmp++; if (out_port !== 8'h00 || oe !== 8'h00) begin n_err++; $display("FAIL ar_out got out=%h oe=%h exp 00/00", out_port, oe); end
        n_cmp++; if (out_port2 !== 8'h5A || oe2 !== 8'h0F) begin n_err++; $display("FAIL ar_out2 got out=%h oe=%h exp 5a/0f", out_port2, oe2); end
        in_port = 8'h00;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(3);
        bus_read(3'd3, r, r2);
        n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL ar_cap got %h exp 00", r); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_outputs();
        test_regmap();
        test_rw_same_cycle();
        test_edge_irq();
        test_set_wins();
        test_any_edge();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
